// File: rtl/fifo_stream_reader_if.sv
// Stream-reader bus: FIFO read port on one side, valid/ready stream on the other.
// valid/ready: a word transfers on a clock edge where valid_o=1 and ready_i=1; once valid_o rises, data_o holds until that edge.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty_i;
  logic [WIDTH-1:0] fifo_data_i;
  logic             fifo_rd_en_o;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic [1:0]       occupancy_o;

  modport master (
    input  fifo_empty_i,
    input  fifo_data_i,
    input  ready_i,
    output fifo_rd_en_o,
    output valid_o,
    output data_o,
    output occupancy_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_data_i,
    output ready_i,
    input  fifo_rd_en_o,
    input  valid_o,
    input  data_o,
    input  occupancy_o
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops a show-ahead FIFO into a two-entry (main + skid) buffer that drives a
// fully registered valid/ready stream; the pop never looks at ready_i.
module fifo_stream_reader #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fifo_stream_reader_if.master bus,
  output logic [1:0]           state_dbg_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             pop;
  logic             hs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    // No pop while in reset: the word would be consumed from the FIFO and dropped.
    pop     = ~bus.fifo_empty_i & (state_q != TWO) & ~rst_i;
    hs      = (state_q != EMPTY) & bus.ready_i;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (pop) begin
          state_d = ONE;
          main_d  = bus.fifo_data_i;
        end
      end
      ONE: begin
        if (pop && hs) begin
          main_d = bus.fifo_data_i;
        end else if (pop) begin
          state_d = TWO;
          skid_d  = bus.fifo_data_i;
        end else if (hs) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (hs) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign bus.fifo_rd_en_o = pop;
  assign bus.valid_o      = (state_q != EMPTY);
  assign bus.data_o       = main_q;
  assign bus.occupancy_o  = (state_q == TWO) ? 2'd2 :
                            (state_q == ONE) ? 2'd1 : 2'd0;
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and random stimulus for fifo_stream_reader against a queue model of
// the source FIFO and of the words held inside the reader.
module tb_fifo_stream_reader;

  logic       clk;
  logic       rst_i;
  logic [1:0] state_dbg;

  fifo_stream_reader_if #(.WIDTH(8)) bus ();

  fifo_stream_reader #(.WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .bus         (bus.master),
    .state_dbg_o (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pop_cnt  = 0;
  int xfer_cnt = 0;

  logic [7:0] src_q[$];  // words still in the source FIFO, head first
  logic [7:0] exp_q[$];  // words popped but not yet transferred, in order

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after negedge, check, take posedge, advance model.
  task automatic cycle(input bit rdy);
    bit pop_m;
    bit hs_m;
    bus.fifo_empty_i = (src_q.size() == 0);
    bus.fifo_data_i  = (src_q.size() != 0) ? src_q[0] : 8'($urandom);
    bus.ready_i      = rdy;
    #1;
    pop_m = (src_q.size() != 0) && (exp_q.size() < 2);
    hs_m  = (exp_q.size() != 0) && rdy;
    chk("rd_en", 32'(bus.fifo_rd_en_o), 32'(pop_m));
    chk("valid", 32'(bus.valid_o), 32'(exp_q.size() != 0));
    chk("occupancy", 32'(bus.occupancy_o), 32'(exp_q.size()));
    if (exp_q.size() != 0) chk("data", 32'(bus.data_o), 32'(exp_q[0]));
    chk("pop_while_empty", 32'(bus.fifo_rd_en_o & bus.fifo_empty_i), 32'd0);
    @(posedge clk);
    if (hs_m) begin
      void'(exp_q.pop_front());
      xfer_cnt++;
    end
    if (pop_m) begin
      exp_q.push_back(src_q.pop_front());
      pop_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    int p0;
    int x0;
    int sent;
    int guard;
    logic [7:0] head;

    // Reset with a non-empty FIFO presenting 8'hA5
    rst_i = 1'b1;
    src_q.push_back(8'hA5);
    bus.fifo_empty_i = 1'b0;
    bus.fifo_data_i  = 8'hA5;
    bus.ready_i      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_data", 32'(bus.data_o), 32'd0);
    chk("rst_occ", 32'(bus.occupancy_o), 32'd0);
    chk("rst_rd_en", 32'(bus.fifo_rd_en_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) cycle(1'b1);
    chk("rst_a5_pops", 32'(pop_cnt), 32'd1);

    // Single word
    p0 = pop_cnt; x0 = xfer_cnt;
    src_q.push_back(8'h11);
    repeat (3) cycle(1'b1);
    chk("single_pops", 32'(pop_cnt - p0), 32'd1);
    chk("single_xfer", 32'(xfer_cnt - x0), 32'd1);

    // Streaming 01..08: one pop per cycle, then one transfer per cycle
    p0 = pop_cnt; x0 = xfer_cnt;
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    repeat (8) cycle(1'b1);
    chk("stream_pops_8cyc", 32'(pop_cnt - p0), 32'd8);
    cycle(1'b1);
    chk("stream_xfer_9cyc", 32'(xfer_cnt - x0), 32'd8);
    cycle(1'b1);

    // Backpressure: only two words leave the FIFO while stalled
    p0 = pop_cnt; x0 = xfer_cnt;
    for (int i = 1; i <= 4; i++) src_q.push_back(8'(i));
    repeat (5) cycle(1'b0);
    chk("bp_pops", 32'(pop_cnt - p0), 32'd2);
    chk("bp_occ", 32'(bus.occupancy_o), 32'd2);
    chk("bp_data", 32'(bus.data_o), 32'h01);
    repeat (6) cycle(1'b1);
    chk("bp_xfer", 32'(xfer_cnt - x0), 32'd4);

    // Random ready and random FIFO refill, 1000 words
    x0 = xfer_cnt; sent = 0; guard = 0;
    while ((sent < 1000 || src_q.size() != 0 || exp_q.size() != 0) && guard < 20000) begin
      if (sent < 1000 && src_q.size() < 4 && $urandom_range(0, 1) == 1) begin
        src_q.push_back(8'($urandom));
        sent++;
      end
      cycle($urandom_range(0, 1) == 1);
      guard++;
    end
    chk("rand_timeout", 32'(guard < 20000), 32'd1);
    chk("rand_xfer", 32'(xfer_cnt - x0), 32'd1000);

    // Reset while holding two words
    for (int i = 0; i < 4; i++) src_q.push_back(8'($urandom));
    repeat (3) cycle(1'b0);
    chk("pre_rst_occ", 32'(bus.occupancy_o), 32'd2);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.valid_o), 32'd0);
    chk("mid_rst_occ", 32'(bus.occupancy_o), 32'd0);
    chk("mid_rst_rd_en", 32'(bus.fifo_rd_en_o), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    head = src_q[0];
    cycle(1'b1);
    chk("resume_head", 32'(bus.data_o), 32'(head));
    repeat (4) cycle(1'b1);
    chk("resume_drained", 32'(exp_q.size() + src_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
